top_share_arb: RTL and testbench
================================

# top_share_arb

Round-robin scheduler that time-shares the single combinational `top` datapath (`in1`/`in2`/`in3` → `out1`) between NREQ operand requesters. It accepts operand triples over per-requester valid/ready, registers the winning triple onto the datapath inputs, captures `out1` one cycle later, and returns the result with the requester ID over a valid/ready response port. It sits between the stimulus or compute clients and the `top` instance, and runs at one transaction per cycle when there is no backpressure.

## Interface
- NREQ, 2, number of requesters (legal 2..4)
- IN_W, 19, operand width (matches `top` in1/in2/in3)
- OUT_W, 20, result width (matches `top` out1)
- ID_W, $clog2(NREQ), response ID width (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has a triple pending
- req_ready  out  NREQ  triple from requester i accepted this cycle
- req_in1 / req_in2 / req_in3  in  NREQ*IN_W each  operands; requester i occupies bits [i*IN_W +: IN_W]
- dp_in1 / dp_in2 / dp_in3  out  IN_W each  registered operands driven to `top`
- dp_out1  in  OUT_W  combinational result from `top`
- rsp_valid  out  1  response holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  OUT_W  captured `dp_out1`
- rsp_id  out  ID_W  index of the requester that issued the triple

## Operation
- Two pipeline stages:
  - S1 (operand register): dp_in*, s1_valid, s1_id.
  - S2 (result register): rsp_data, rsp_valid, rsp_id.
- S2 load enable: `ld2 = !rsp_valid || rsp_ready`.
  - When ld2 is high, S2 loads `dp_out1` and s1_id, and sets rsp_valid = s1_valid.
- S1 load enable: `ld1 = !s1_valid || ld2`.
  - When ld1 is high and a grant exists, S1 loads the granted triple and sets s1_valid = 1.
  - When ld1 is high and there is no grant, s1_valid is set to 0 and dp_in* hold their values.
- Arbiter:
  - Round-robin pointer `ptr`. The grant goes to the first i with req_valid[i], searching from ptr upward and wrapping modulo NREQ.
  - `req_ready[i] = grant[i] & ld1`. At most one bit of req_ready is high.
  - ptr advances to (granted+1) mod NREQ only on an accepted transfer. Otherwise ptr holds.
- The grant depends only on registered ptr and the current req_valid, so there is no combinational path from rsp_ready to the grant choice. req_ready does depend combinationally on rsp_ready through ld1/ld2.
- Requesters must hold req_valid and their operands stable until req_ready. Dropping req_valid early is a protocol violation and the behaviour is not specified.
- Simultaneous events:
  - A new accept and an S2 drain in the same cycle both occur; the pipeline does not bubble.
  - All NREQ requesters valid together are served in pointer order, one per cycle.

## Timing
- Latency: an accept on edge N places operands on dp_in* after N. rsp_valid rises after edge N+1.
- Throughput: 1 triple per cycle when rsp_ready stays high.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_id hold. S1 holds if full, and req_ready is low when S1 is full.
- Reset (synchronous; takes effect at the rising edge where rst=1). All outputs clear:
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0
  - dp_in1 = dp_in2 = dp_in3 = 0
  - s1_valid = 0, ptr = 0
- While rst is high, req_ready is forced to 0.
- Reset mid-operation discards in-flight S1/S2 contents without producing a response. The first grant after reset favours requester 0.

## Structure
- Package `top_share_pkg`:
  - localparams `TOP_IN_W=19` and `TOP_OUT_W=20`
  - function `id_w(nreq)`
  - typedef `operand_t` struct {in1, in2, in3}
- Sub-module `rr_arbiter`:
  - parameter N; inputs req[N], advance, clk, rst
  - outputs grant[N] (one-hot) and grant_idx
  - owns ptr
- The top level instantiates `rr_arbiter` and the two stage registers only. The `top` datapath is instantiated outside this block.

## Test plan
- Single request: requester 1 sends (3,5,7) with rsp_ready=1 → req_ready[1] in the same cycle; rsp_valid two edges later with rsp_id=1 and rsp_data equal to the model `top(3,5,7)`.
- Contention: all requesters held valid for 8 cycles with NREQ=3 → rsp_id sequence 0,1,2,0,1,2,0,1 with no bubbles.
- Backpressure: rsp_ready=0 for 5 cycles while requests are pending → rsp_data and rsp_id stable; exactly 2 transfers accepted (S1 and S2 full); after release, results emerge in order and none are lost.
- Width boundary: operands 19'h7FFFF, 19'h7FFFF, 19'h7FFFF and 0,0,0 → rsp_data matches the 20-bit model output exactly.
- Reset mid-flight: assert rst for 1 cycle while S1 and S2 are full → next cycle rsp_valid=0 and dp_in*=0; next contention grants requester 0 first.
- Exhaustive sweep: requester 0 drives in1,in2,in3 over 0..15 each (4096 triples) with random rsp_ready → every response matches the model, in order.

Source files
------------

// File: rtl/top_share_pkg.sv
// Shared widths, ID-width helper and operand bundle for the top_share_arb scheduler.
package top_share_pkg;

  localparam int unsigned TOP_IN_W  = 19;
  localparam int unsigned TOP_OUT_W = 20;

  function automatic int unsigned id_w(input int unsigned nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  typedef struct packed {
    logic [TOP_IN_W-1:0] in1;
    logic [TOP_IN_W-1:0] in2;
    logic [TOP_IN_W-1:0] in3;
  } operand_t;

endpackage

// File: rtl/top_share_arb_if.sv
// Request, datapath and response signals between clients, the scheduler and the top datapath.
interface top_share_arb_if
  import top_share_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IN_W  = TOP_IN_W,
  parameter int unsigned OUT_W = TOP_OUT_W
);
  localparam int unsigned ID_W = id_w(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_in1;
  logic [NREQ*IN_W-1:0] req_in2;
  logic [NREQ*IN_W-1:0] req_in3;
  logic [IN_W-1:0]      dp_in1;
  logic [IN_W-1:0]      dp_in2;
  logic [IN_W-1:0]      dp_in3;
  logic [OUT_W-1:0]     dp_out1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;

  modport master (
    output req_valid, req_in1, req_in2, req_in3, dp_out1, rsp_ready,
    input  req_ready, dp_in1, dp_in2, dp_in3, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_in3, dp_out1, rsp_ready,
    output req_ready, dp_in1, dp_in2, dp_in3, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/top_share_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping modulo N.
module rr_arbiter
  import top_share_pkg::*;
#(
  parameter  int unsigned N    = 2,
  localparam int unsigned ID_W = id_w(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_advance,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_idx
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = ID_W'((32'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
        w_found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_grant_idx == ID_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/top_share_arb.sv
// Time-shares one combinational top datapath between NREQ requesters through a
// two-stage (operand register, result register) valid/ready pipeline.
module top_share_arb
  import top_share_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IN_W  = TOP_IN_W,
  parameter int unsigned OUT_W = TOP_OUT_W
) (
  input logic             clk,
  input logic             rst,
  top_share_arb_if.slave  bus
);

  localparam int unsigned ID_W = id_w(NREQ);

  typedef struct packed {
    logic [IN_W-1:0] in1;
    logic [IN_W-1:0] in2;
    logic [IN_W-1:0] in3;
  } opnd_t;

  logic [NREQ-1:0]  w_grant;
  logic [ID_W-1:0]  w_grant_idx;
  logic [NREQ-1:0]  w_ready;
  logic             w_ld1;
  logic             w_ld2;
  logic             w_any;
  opnd_t            w_sel;

  opnd_t            r_s1;
  logic             r_s1_valid;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_rsp_valid;
  logic [OUT_W-1:0] r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.req_valid),
    .i_advance   (|w_ready),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_ld2   = !r_rsp_valid || bus.rsp_ready;
  assign w_ld1   = !r_s1_valid || w_ld2;
  assign w_any   = |w_grant;
  assign w_ready = rst ? '0 : (w_grant & {NREQ{w_ld1}});

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel.in1 = bus.req_in1[i*IN_W +: IN_W];
        w_sel.in2 = bus.req_in2[i*IN_W +: IN_W];
        w_sel.in3 = bus.req_in3[i*IN_W +: IN_W];
      end
    end
  end

  // S2 samples dp_out1 whenever it may load; rsp_valid qualifies the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      if (w_ld2) begin
        r_rsp_valid <= r_s1_valid;
        r_rsp_data  <= bus.dp_out1;
        r_rsp_id    <= r_s1_id;
      end
      if (w_ld1) begin
        r_s1_valid <= w_any;
        if (w_any) begin
          r_s1    <= w_sel;
          r_s1_id <= w_grant_idx;
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.dp_in1    = r_s1.in1;
  assign bus.dp_in2    = r_s1.in2;
  assign bus.dp_in3    = r_s1.in3;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_top_share_arb.sv
// Directed bench for top_share_arb with NREQ=3 and a stand-in top datapath.
module tb_top_share_arb;
  import top_share_pkg::*;

  typedef struct {
    int unsigned r;
    operand_t    op;
    logic [19:0] exp;
    logic [1:0]  id;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic acc;
  int unsigned nacc, nrsp, item, sidx;
  logic [19:0] q[$];
  logic [19:0] e;
  vec_t vecs[6];
  logic [19:0] cont_exp[3];
  logic [2:0] exp_rdy;

  always #5 clk = ~clk;

  top_share_arb_if #(.NREQ(3), .IN_W(19), .OUT_W(20)) sif ();

  top_share_arb #(.NREQ(3), .IN_W(19), .OUT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Stand-in for the external top datapath.
  function automatic logic [19:0] dp_model(input logic [18:0] a, input logic [18:0] b,
                                           input logic [18:0] c);
    return ({1'b0, a} + {1'b0, b}) ^ {1'b0, c};
  endfunction

  assign sif.dp_out1 = dp_model(sif.dp_in1, sif.dp_in2, sif.dp_in3);

  function automatic operand_t mk(input logic [18:0] a, input logic [18:0] b,
                                  input logic [18:0] c);
    operand_t o;
    o.in1 = a;
    o.in2 = b;
    o.in3 = c;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int unsigned r, input operand_t op);
    sif.req_in1[r*19 +: 19] = op.in1;
    sif.req_in2[r*19 +: 19] = op.in2;
    sif.req_in3[r*19 +: 19] = op.in3;
  endtask

  task automatic drain();
    sif.req_valid = '0;
    sif.rsp_ready = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    vecs[0] = '{r: 1, op: mk(19'd3, 19'd5, 19'd7),                id: 2'd1, exp: 20'h0000F};
    vecs[1] = '{r: 0, op: mk(19'h7FFFF, 19'h7FFFF, 19'h7FFFF),    id: 2'd0, exp: 20'h80001};
    vecs[2] = '{r: 2, op: mk(19'd0, 19'd0, 19'd0),                id: 2'd2, exp: 20'h00000};
    vecs[3] = '{r: 0, op: mk(19'h7FFFF, 19'h00001, 19'h00000),    id: 2'd0, exp: 20'h80000};
    vecs[4] = '{r: 2, op: mk(19'h12345, 19'h00001, 19'h7FFFF),    id: 2'd2, exp: 20'h6DCB9};
    vecs[5] = '{r: 1, op: mk(19'h40000, 19'h40000, 19'h00003),    id: 2'd1, exp: 20'h80003};
    cont_exp[0] = 20'd7;
    cont_exp[1] = 20'd2;
    cont_exp[2] = 20'd13;

    // Reset state, with all requesters asserting to confirm req_ready is forced low
    rst = 1'b1;
    sif.req_in1 = '0;
    sif.req_in2 = '0;
    sif.req_in3 = '0;
    sif.req_valid = 3'b111;
    sif.rsp_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", 32'(sif.req_ready), 0);
    chk("rst_rsp_valid", 32'(sif.rsp_valid), 0);
    chk("rst_rsp_data", 32'(sif.rsp_data), 0);
    chk("rst_rsp_id", 32'(sif.rsp_id), 0);
    chk("rst_dp_in1", 32'(sif.dp_in1), 0);
    chk("rst_dp_in2", 32'(sif.dp_in2), 0);
    chk("rst_dp_in3", 32'(sif.dp_in3), 0);
    rst = 1'b0;
    sif.req_valid = '0;
    step();

    // Contention: all three valid for 8 cycles
    for (int unsigned r = 0; r < 3; r++)
      set_ops(r, mk(19'(r + 1), 19'(2 * (r + 1)), 19'd4));
    sif.req_valid = 3'b111;
    #1;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        exp_rdy = 3'(1 << (c % 3));
        chk("cont_ready", 32'(sif.req_ready), 32'(exp_rdy));
      end
      step();
      if (c == 7) sif.req_valid = '0;
      if (c >= 1) begin
        chk("cont_valid", 32'(sif.rsp_valid), 1);
        chk("cont_id", 32'(sif.rsp_id), 32'((c - 1) % 3));
        chk("cont_data", 32'(sif.rsp_data), 32'(cont_exp[(c - 1) % 3]));
      end
      #1;
    end
    drain();

    // Single-request vectors on an idle pipeline
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].r, vecs[v].op);
      sif.req_valid = 3'(1 << vecs[v].r);
      #1;
      chk("vec_ready", 32'(sif.req_ready), 32'(1 << vecs[v].r));
      step();
      sif.req_valid = '0;
      chk("vec_dp_in1", 32'(sif.dp_in1), 32'(vecs[v].op.in1));
      chk("vec_rsp_early", 32'(sif.rsp_valid), 0);
      step();
      chk("vec_rsp_valid", 32'(sif.rsp_valid), 1);
      chk("vec_rsp_data", 32'(sif.rsp_data), 32'(vecs[v].exp));
      chk("vec_rsp_id", 32'(sif.rsp_id), 32'(vecs[v].id));
      step();
    end
    drain();

    // Backpressure: rsp_ready low for 5 cycles, requester 0 streaming items
    sif.rsp_ready = 1'b0;
    item = 0;
    nacc = 0;
    set_ops(0, mk(19'd10, 19'd0, 19'd0));
    sif.req_valid = 3'b001;
    #1;
    for (int c = 0; c < 5; c++) begin
      acc = sif.req_ready[0];
      step();
      if (acc) begin
        nacc++;
        item++;
        if (item < 4) set_ops(0, mk(19'(10 + item), 19'(item), 19'd0));
        else sif.req_valid = '0;
      end
      if (c >= 1) begin
        chk("bp_hold_valid", 32'(sif.rsp_valid), 1);
        chk("bp_hold_data", 32'(sif.rsp_data), 32'h0000A);
        chk("bp_hold_id", 32'(sif.rsp_id), 0);
      end
      #1;
    end
    chk("bp_accepts", nacc, 2);
    sif.rsp_ready = 1'b1;
    nrsp = 0;
    #1;
    for (int c = 0; c < 30 && nrsp < 4; c++) begin
      acc = sif.req_ready[0] && sif.req_valid[0];
      if (sif.rsp_valid) begin
        chk("bp_order", 32'(sif.rsp_data), 32'(10 + 2 * nrsp));
        nrsp++;
      end
      step();
      if (acc) begin
        item++;
        if (item < 4) set_ops(0, mk(19'(10 + item), 19'(item), 19'd0));
        else sif.req_valid = '0;
      end
      #1;
    end
    chk("bp_rsp_count", nrsp, 4);
    drain();

    // Reset with S1 and S2 both full
    sif.rsp_ready = 1'b0;
    set_ops(1, mk(19'h00111, 19'h00222, 19'h00333));
    sif.req_valid = 3'b010;
    step();
    step();
    chk("mid_s2_full", 32'(sif.rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(sif.req_ready), 0);
    step();
    rst = 1'b0;
    chk("mid_rsp_valid", 32'(sif.rsp_valid), 0);
    chk("mid_dp_in1", 32'(sif.dp_in1), 0);
    chk("mid_dp_in2", 32'(sif.dp_in2), 0);
    chk("mid_dp_in3", 32'(sif.dp_in3), 0);
    sif.req_valid = 3'b111;
    sif.rsp_ready = 1'b1;
    #1;
    chk("mid_first_grant", 32'(sif.req_ready), 32'h1);
    step();
    sif.req_valid = '0;
    drain();

    // Sweep requester 0 over 4096 triples with random rsp_ready
    sidx = 0;
    nrsp = 0;
    q.delete();
    set_ops(0, mk(19'd0, 19'd0, 19'd0));
    sif.req_valid = 3'b001;
    for (int c = 0; c < 20000 && nrsp < 4096; c++) begin
      sif.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      acc = sif.req_ready[0] && sif.req_valid[0];
      if (sif.rsp_valid && sif.rsp_ready) begin
        if (q.size() == 0) begin
          chk("sweep_spurious", 32'(sif.rsp_data), 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          chk("sweep_data", 32'(sif.rsp_data), 32'(e));
          chk("sweep_id", 32'(sif.rsp_id), 0);
        end
        nrsp++;
      end
      if (acc) q.push_back(dp_model(19'((sidx >> 8) & 15), 19'((sidx >> 4) & 15), 19'(sidx & 15)));
      step();
      if (acc) begin
        sidx++;
        if (sidx == 4096) sif.req_valid = '0;
        else set_ops(0, mk(19'((sidx >> 8) & 15), 19'((sidx >> 4) & 15), 19'(sidx & 15)));
      end
    end
    chk("sweep_count", nrsp, 4096);
    chk("sweep_accepts", sidx, 4096);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
